// File: rtl/psum_acc_if.sv
// rtl/psum_acc_if.sv - handshake and strobe bundle between issuer, psum FIFO, output writer and psum_acc_ctrl
interface psum_acc_if #(
    parameter int LEN_W  = 8,
    parameter int PASS_W = 10
);
    logic              start;
    logic [LEN_W-1:0]  cfg_len;
    logic [PASS_W-1:0] cfg_passes;
    logic              pe_valid;
    logic              pe_ready;
    logic              fifo_full;
    logic              fifo_rd_en;
    logic              fifo_wr_en;
    logic              fifo_zero_sel;
    logic              out_valid;
    logic              out_last;
    logic              busy;
    logic              done;
    logic              err;

    modport slave (
        input  start, cfg_len, cfg_passes, pe_valid, fifo_full,
        output pe_ready, fifo_rd_en, fifo_wr_en, fifo_zero_sel,
               out_valid, out_last, busy, done, err
    );

    modport master (
        output start, cfg_len, cfg_passes, pe_valid, fifo_full,
        input  pe_ready, fifo_rd_en, fifo_wr_en, fifo_zero_sel,
               out_valid, out_last, busy, done, err
    );
endinterface

// File: rtl/psum_acc_ctrl.sv
// rtl/psum_acc_ctrl.sv - pass/position sequencer and tag pipeline driving the psum adder tree and FIFO
module psum_acc_ctrl #(
    parameter int ADDER_LAT = 3,
    parameter int LEN_W     = 8,
    parameter int PASS_W    = 10
) (
    input  logic      clk,
    input  logic      rst_n,
    psum_acc_if.slave bus
);
    localparam int STALL_W = $clog2(ADDER_LAT + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic valid;
        logic first;
        logic last_pass;
        logic last_pos;
    } tag_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, pos_q;
    logic [PASS_W-1:0] passes_q, pass_q;
    logic [STALL_W-1:0] stall_q, stall_load;
    tag_t              tag_q [ADDER_LAT];
    tag_t              new_tag, out_tag;
    logic              err_q;

    logic start_ok, zero_cfg, accept, pos_last, pass_last;
    logic ready, busy, rd_en, wr_en, zero_sel, out_valid, out_last;

    assign start_ok  = (state_q == IDLE) && bus.start;
    assign zero_cfg  = (bus.cfg_len == '0) || (bus.cfg_passes == '0);
    assign ready     = (state_q == RUN) && (stall_q == '0);
    assign accept    = bus.pe_valid && ready;
    assign pos_last  = (pos_q == len_q - 1'b1);
    assign pass_last = (pass_q == passes_q - 1'b1);
    assign busy      = (state_q != IDLE);

    // Rows shorter than the adder latency must wait so a FIFO entry is written before it is popped again
    always_comb begin
        stall_load = '0;
        if (len_q < LEN_W'(ADDER_LAT))
            stall_load = STALL_W'(LEN_W'(ADDER_LAT) - len_q);
    end

    always_comb begin
        new_tag           = '0;
        new_tag.valid     = accept;
        new_tag.first     = accept && (pass_q == '0);
        new_tag.last_pass = accept && pass_last;
        new_tag.last_pos  = accept && pos_last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (bus.start) state_d = zero_cfg ? DONE : RUN;
            RUN:   if (accept && pos_last && pass_last) state_d = DRAIN;
            // The final tag one stage before the tree output means the last result lands next cycle
            DRAIN: if (tag_q[ADDER_LAT-2].valid && tag_q[ADDER_LAT-2].last_pass &&
                       tag_q[ADDER_LAT-2].last_pos) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q    <= '0;
            passes_q <= '0;
            pos_q    <= '0;
            pass_q   <= '0;
            stall_q  <= '0;
        end else if (start_ok) begin
            len_q    <= bus.cfg_len;
            passes_q <= bus.cfg_passes;
            pos_q    <= '0;
            pass_q   <= '0;
            stall_q  <= '0;
        end else if (accept) begin
            if (pos_last) begin
                pos_q <= '0;
                if (!pass_last) begin
                    pass_q  <= pass_q + 1'b1;
                    stall_q <= stall_load;
                end
            end else begin
                pos_q <= pos_q + 1'b1;
            end
        end else if (stall_q != '0) begin
            stall_q <= stall_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ADDER_LAT; i++) tag_q[i] <= '0;
        end else begin
            tag_q[0] <= new_tag;
            for (int i = 1; i < ADDER_LAT; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    assign out_tag   = tag_q[ADDER_LAT-1];
    assign rd_en     = tag_q[0].valid && !tag_q[0].first;
    assign zero_sel  = busy && (!tag_q[1].valid || tag_q[1].first);
    assign out_valid = out_tag.valid && out_tag.last_pass;
    assign out_last  = out_valid && out_tag.last_pos;
    assign wr_en     = out_tag.valid && !out_tag.last_pass;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               err_q <= 1'b0;
        else if (start_ok)        err_q <= zero_cfg;
        else if (wr_en && bus.fifo_full) err_q <= 1'b1;
    end

    assign bus.pe_ready      = ready;
    assign bus.fifo_rd_en    = rd_en;
    assign bus.fifo_wr_en    = wr_en;
    assign bus.fifo_zero_sel = zero_sel;
    assign bus.out_valid     = out_valid;
    assign bus.out_last      = out_last;
    assign bus.busy          = busy;
    assign bus.done          = (state_q == DONE);
    assign bus.err           = err_q;
endmodule
